// File: rtl/gate_lib_arbiter.sv
// gate_lib_arbiter
//   Round-robin arbiter in front of a shared 13-function gate-library
//   evaluator. Up to NREQ requesters present an opcode and four operand bits;
//   one request per cycle is granted, evaluated, and placed in a single
//   registered response slot that the consumer drains with rsp_ready.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   req_valid      : per-requester request valid
//   req_op         : opcode of requester i in [4i+3:4i]
//   req_in         : operands {d,c,b,a} of requester i in [4i+3:4i]
//   req_ready      : combinational grant, one-hot or zero
//   rsp_valid      : response slot is full
//   rsp_id         : requester index owning the response
//   rsp_data       : gate result (0 for illegal opcodes)
//   rsp_err        : opcode was illegal (13..15)
//   rsp_ready      : consumer accepts the response
//   err_cnt        : saturating count of accepted illegal opcodes
module gate_lib_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_op,
   input  logic [4*NREQ-1:0] req_in,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_data,
   output logic              rsp_err,
   input  logic              rsp_ready,
   output logic [7:0]        err_cnt
);

   typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

   slot_state_t    state_reg;
   logic [IDW-1:0] ptr_reg;
   logic [IDW-1:0] rsp_id_reg;
   logic           rsp_data_reg;
   logic           rsp_err_reg;
   logic [7:0]     err_cnt_reg;

   logic [3:0]     op_arr [NREQ];
   logic [3:0]     in_arr [NREQ];

   logic           any_valid;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] cand;
   logic           can_accept;
   logic           transfer;
   logic [3:0]     win_op;
   logic [3:0]     win_in;
   logic           win_illegal;

   // (base + k) mod NREQ; works for non-power-of-two NREQ.
   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return s[IDW-1:0];
   endfunction

   function automatic logic gate_eval(input logic [3:0] op, input logic [3:0] v);
      logic a, b, c, d;
      {d, c, b, a} = v;
      case (op)
         4'd0:    return ~a;
         4'd1:    return a & b;
         4'd2:    return ~(a & b);
         4'd3:    return a & ~b;
         4'd4:    return a | b;
         4'd5:    return ~(a | b);
         4'd6:    return a | ~b;
         4'd7:    return a ^ b;
         4'd8:    return ~(a ^ b);
         4'd9:    return ~((a & b) | c);
         4'd10:   return ~((a | b) & c);
         4'd11:   return ~((a & b) | (c & d));
         4'd12:   return ~((a | b) & (c | d));
         default: return 1'b0;
      endcase
   endfunction

   // Unpack the flat request buses and drive the per-requester grants.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign op_arr[gi]    = req_op[4*gi+3:4*gi];
         assign in_arr[gi]    = req_in[4*gi+3:4*gi];
         assign req_ready[gi] = transfer && (winner == IDW'(gi));
      end
   endgenerate

   // First valid requester in the order ptr, ptr+1, ... (mod NREQ).
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = wrap_add(ptr_reg, k);
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            winner    = cand;
         end
      end
   end

   // The grant never looks at req_ready, only at the request and slot state.
   assign can_accept  = (state_reg == SLOT_EMPTY) || rsp_ready;
   assign transfer    = !rst && any_valid && can_accept;
   assign win_op      = op_arr[winner];
   assign win_in      = in_arr[winner];
   assign win_illegal = (win_op > 4'd12);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= SLOT_EMPTY;
         ptr_reg      <= '0;
         rsp_id_reg   <= '0;
         rsp_data_reg <= 1'b0;
         rsp_err_reg  <= 1'b0;
         err_cnt_reg  <= 8'd0;
      end else begin
         if (transfer) begin
            // Covers both EMPTY->FULL and the back-to-back FULL->FULL refill.
            state_reg    <= SLOT_FULL;
            rsp_id_reg   <= winner;
            rsp_data_reg <= win_illegal ? 1'b0 : gate_eval(win_op, win_in);
            rsp_err_reg  <= win_illegal;
            ptr_reg      <= wrap_add(winner, 1);
            if (win_illegal && (err_cnt_reg != 8'hFF))
               err_cnt_reg <= err_cnt_reg + 8'd1;
         end else if (rsp_ready) begin
            state_reg <= SLOT_EMPTY;
         end
      end
   end

   assign rsp_valid = (state_reg == SLOT_FULL);
   assign rsp_id    = rsp_id_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_err   = rsp_err_reg;
   assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_gate_lib_arbiter.sv
// Directed testbench for gate_lib_arbiter with NREQ=4.
module tb_gate_lib_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_op;
   logic [4*NREQ-1:0] req_in;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_data;
   logic              rsp_err;
   logic              rsp_ready;
   logic [7:0]        err_cnt;

   int errors = 0;
   int checks = 0;

   // Hand-derived truth tables: bit i is the result for {d,c,b,a} = i.
   logic [15:0] tt [0:12];

   gate_lib_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_in    (req_in),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [3:0] v);
      req_op[4*i +: 4] = op;
      req_in[4*i +: 4] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      tick();
      tick();
      rst = 1'b0;
      req_valid = '0;
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt} !== 13'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b id=%0d d=%b e=%b cnt=%0d want all 0",
                  rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt);
      end
   endtask

   task automatic test_oai4();
      set_req(0, 4'd12, 4'b0001);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL oai4_ready: got %b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
      $display("txn id=%0d data=%b err=%b", rsp_id, rsp_data, rsp_err);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL oai4_rsp: got v=%b id=%0d d=%b e=%b want v=1 id=0 d=1 e=0",
                  rsp_valid, rsp_id, rsp_data, rsp_err);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL oai4_drain: got v=%b want 0", rsp_valid);
      end
   endtask

   task automatic test_sweep();
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      for (int op = 0; op < 13; op++) begin
         for (int v = 0; v < 16; v++) begin
            logic [15:0] row;
            logic exp_d;
            row   = tt[op];
            exp_d = row[v];
            set_req(2, op[3:0], v[3:0]);
            tick();
            $display("txn id=%0d op=%0d in=%0d data=%b err=%b", rsp_id, op, v, rsp_data, rsp_err);
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd2, 1'b0, exp_d}) begin
               errors++;
               $display("FAIL sweep op=%0d in=%0d: got v=%b id=%0d e=%b d=%b want v=1 id=2 e=0 d=%b",
                        op, v, rsp_valid, rsp_id, rsp_err, rsp_data, exp_d);
            end
         end
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_fairness();
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 4'd1, 4'b0011);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         logic [3:0] exp_rdy;
         exp_rdy = 4'b0001 << (k % 4);
         #1;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL fair_ready k=%0d: got %b want %b", k, req_ready, exp_rdy);
         end
         tick();
         $display("txn id=%0d data=%b err=%b", rsp_id, rsp_data, rsp_err);
         checks++;
         if ({rsp_valid, rsp_id} !== {1'b1, 2'(k % 4)}) begin
            errors++;
            $display("FAIL fair_rsp k=%0d: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, k % 4);
         end
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      set_req(1, 4'd4, 4'b0001);
      set_req(3, 4'd0, 4'b0000);
      req_valid = 4'b1010;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_first_ready: got %b want 0010", req_ready);
      end
      tick();
      $display("txn id=%0d data=%b err=%b", rsp_id, rsp_data, rsp_err);
      checks++;
      if ({rsp_valid, rsp_id} !== {1'b1, 2'd1}) begin
         errors++;
         $display("FAIL bp_first_rsp: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id);
      end
      req_valid = 4'b1000;
      rsp_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_stall_ready s=%0d: got %b want 0000", s, req_ready);
         end
         tick();
         checks++;
         if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL bp_stall_hold s=%0d: got v=%b id=%0d d=%b want v=1 id=1 d=1",
                     s, rsp_valid, rsp_id, rsp_data);
         end
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 1000", req_ready);
      end
      tick();
      req_valid = '0;
      $display("txn id=%0d data=%b err=%b", rsp_id, rsp_data, rsp_err);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 1'b1}) begin
         errors++;
         $display("FAIL bp_second_rsp: got v=%b id=%0d d=%b want v=1 id=3 d=1",
                  rsp_valid, rsp_id, rsp_data);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got v=%b want 0", rsp_valid);
      end
   endtask

   task automatic test_illegal();
      set_req(1, 4'd14, 4'b1111);
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         $display("txn id=%0d data=%b err=%b cnt=%0d", rsp_id, rsp_data, rsp_err, err_cnt);
         checks++;
         if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL illegal_rsp n=%0d: got v=%b id=%0d e=%b d=%b want v=1 id=1 e=1 d=0",
                     n, rsp_valid, rsp_id, rsp_err, rsp_data);
         end
      end
      req_valid = '0;
      tick();
      checks++;
      if (err_cnt !== 8'd5) begin
         errors++;
         $display("FAIL illegal_cnt: got %0d want 5", err_cnt);
      end
   endtask

   task automatic test_saturate();
      int exp_cnt;
      exp_cnt = 5;
      set_req(0, 4'd15, 4'b1111);
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         tick();
         if (exp_cnt < 255) exp_cnt++;
         $display("txn id=%0d err=%b cnt=%0d", rsp_id, rsp_err, err_cnt);
         checks++;
         if ({rsp_err, rsp_data, err_cnt} !== {1'b1, 1'b0, 8'(exp_cnt)}) begin
            errors++;
            $display("FAIL sat n=%0d: got e=%b d=%b cnt=%0d want e=1 d=0 cnt=%0d",
                     n, rsp_err, rsp_data, err_cnt, exp_cnt);
         end
      end
      req_valid = '0;
      tick();
      checks++;
      if (err_cnt !== 8'd255) begin
         errors++;
         $display("FAIL sat_final: got %0d want 255", err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      set_req(0, 4'd1, 4'b0011);
      req_valid = 4'b0001;
      tick();
      checks++;
      if ({rsp_valid, rsp_data} !== 2'b11) begin
         errors++;
         $display("FAIL rmid_full: got v=%b d=%b want v=1 d=1", rsp_valid, rsp_data);
      end
      rst = 1'b1;
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL rmid_ready_in_rst: got %b want 0000", req_ready);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, err_cnt} !== {1'b0, 2'd0, 8'd0}) begin
         errors++;
         $display("FAIL rmid_state: got v=%b id=%0d cnt=%0d want v=0 id=0 cnt=0",
                  rsp_valid, rsp_id, err_cnt);
      end
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rmid_first_grant: got %b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
      $display("txn id=%0d data=%b err=%b", rsp_id, rsp_data, rsp_err);
      checks++;
      if ({rsp_valid, rsp_id} !== {1'b1, 2'd0}) begin
         errors++;
         $display("FAIL rmid_first_rsp: got v=%b id=%0d want v=1 id=0", rsp_valid, rsp_id);
      end
   endtask

   initial begin
      tt[0]  = 16'h5555;  // ~a
      tt[1]  = 16'h8888;  // a&b
      tt[2]  = 16'h7777;  // ~(a&b)
      tt[3]  = 16'h2222;  // a&~b
      tt[4]  = 16'hEEEE;  // a|b
      tt[5]  = 16'h1111;  // ~(a|b)
      tt[6]  = 16'hBBBB;  // a|~b
      tt[7]  = 16'h6666;  // a^b
      tt[8]  = 16'h9999;  // ~(a^b)
      tt[9]  = 16'h0707;  // ~((a&b)|c)
      tt[10] = 16'h1F1F;  // ~((a|b)&c)
      tt[11] = 16'h0777;  // ~((a&b)|(c&d))
      tt[12] = 16'h111F;  // ~((a|b)&(c|d))

      rst       = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_in    = '0;
      rsp_ready = 1'b0;

      test_reset();
      test_oai4();
      test_sweep();
      test_fairness();
      test_backpressure();
      test_illegal();
      test_saturate();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
